mem_arbiter: RTL and testbench

Shares the accelerator's single external memory port between the bus interface units (weight BIU, feature-map BIU, output write-back BIU). Each requester holds a `req` line for a whole burst. The arbiter grants one owner round-robin and passes that owner's request handshake through to memory. It routes read responses back to the owner and keeps the grant until the owner releases it and all of its reads have returned.

---
 rtl/mem_arbiter_if.sv | 63 ++++++
 rtl/mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundle of every signal between the memory arbiter, its requesters (the
// weight, feature-map and output write-back BIUs) and the external memory
// port.
//
// Handshake semantics (all channels): a transfer happens on a rising clk edge
// where valid and ready are both 1. A requester keeps valid and its payload
// stable until it sees ready; ready may depend combinationally on valid.
//
// Signals (requester i uses bit i, or the slice [i*AW +: AW] / [i*DW +: DW]):
//   req, grant                    bus ownership request / one-hot grant
//   req_vld/we/addr/wdata/rdy     per-requester command channel
//   mem_vld/we/addr/wdata/rdy     command channel to memory
//   mem_rsp_vld/addr/data/rdy     read-response channel from memory
//   rsp_vld/rdy, rsp_addr/data    per-requester response channel
//   orphan                        response arrived while nobody owned the bus
//
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters + memory)
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 32,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    req_vld;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_rdy;
  logic               mem_vld;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic               mem_rdy;
  logic               mem_rsp_vld;
  logic [AW-1:0]      mem_rsp_addr;
  logic [DW-1:0]      mem_rsp_data;
  logic               mem_rsp_rdy;
  logic [NREQ-1:0]    rsp_vld;
  logic [NREQ-1:0]    rsp_rdy;
  logic [AW-1:0]      rsp_addr;
  logic [DW-1:0]      rsp_data;
  logic               orphan;

  modport slave (
    input  req, req_vld, req_we, req_addr, req_wdata, mem_rdy,
           mem_rsp_vld, mem_rsp_addr, mem_rsp_data, rsp_rdy,
    output grant, req_rdy, mem_vld, mem_we, mem_addr, mem_wdata,
           mem_rsp_rdy, rsp_vld, rsp_addr, rsp_data, orphan
  );

  modport master (
    output req, req_vld, req_we, req_addr, req_wdata, mem_rdy,
           mem_rsp_vld, mem_rsp_addr, mem_rsp_data, rsp_rdy,
    input  grant, req_rdy, mem_vld, mem_we, mem_addr, mem_wdata,
           mem_rsp_rdy, rsp_vld, rsp_addr, rsp_data, orphan
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one external memory port between NREQ bus interface units. One owner
// is granted round-robin; its command channel is passed straight through to
// memory and read responses are routed straight back to it (no buffering, no
// added latency). The grant is held until the owner drops req AND every read
// it issued has returned.
//
// Ports:
//   clk            clock
//   rst_n          synchronous active-low reset
//   io_bus         mem_arbiter_if.slave (requester + memory channels)
//   o_dbg_state    current FSM state (0 IDLE, 1 GRANT, 2 DRAIN)
//   o_dbg_out_cnt  number of reads issued by the owner still awaiting response
//
// MAX_OUT must be a power of two.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int NREQ    = 3,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAX_OUT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mem_arbiter_if.slave             io_bus,
  output logic [1:0]               o_dbg_state,
  output logic [$clog2(MAX_OUT):0] o_dbg_out_cnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_OUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [NREQ-1:0] r_grant, w_grant_nxt;
  // r_last doubles as the owner index while in GRANT/DRAIN.
  logic [IW-1:0]   r_last, w_last_nxt;
  logic [CW-1:0]   r_out_cnt, w_out_cnt_nxt;

  logic            w_pick_vld;
  logic [IW-1:0]   w_pick_idx;
  logic            w_own_req;
  logic            w_own_vld;
  logic            w_own_we;
  logic            w_blocked;
  logic            w_rd_acc;
  logic            w_rsp_hs;

  assign w_own_req = io_bus.req[r_last];
  assign w_own_vld = io_bus.req_vld[r_last];
  assign w_own_we  = io_bus.req_we[r_last];

  // Only reads consume an outstanding slot, so only reads are throttled.
  assign w_blocked = !w_own_we && (r_out_cnt == CW'(MAX_OUT));

  assign w_rd_acc = rst_n && (r_state == S_GRANT) && w_own_vld && !w_blocked &&
                    io_bus.mem_rdy && !w_own_we;
  // Responses accepted in IDLE are orphans and never touch the counter.
  assign w_rsp_hs = rst_n && (r_state != S_IDLE) && io_bus.mem_rsp_vld &&
                    io_bus.rsp_rdy[r_last];

  always_comb begin
    w_out_cnt_nxt = r_out_cnt;
    case ({w_rd_acc, w_rsp_hs})
      2'b10:   w_out_cnt_nxt = r_out_cnt + CW'(1);
      2'b01:   w_out_cnt_nxt = r_out_cnt - CW'(1);
      default: w_out_cnt_nxt = r_out_cnt;
    endcase
  end

  // Round-robin pick: first set req bit at last+1, last+2, ... (mod NREQ).
  // Scanning from the far end backwards lets the nearest hit win.
  always_comb begin
    int v_idx;
    v_idx      = 0;
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      v_idx = (int'(r_last) + k) % NREQ;
      if (io_bus.req[v_idx]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = IW'(v_idx);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_last    <= IW'(NREQ - 1);
      r_out_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_last    <= w_last_nxt;
      r_out_cnt <= w_out_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    case (r_state)
      S_IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = S_GRANT;
          w_grant_nxt = NREQ'(1) << w_pick_idx;
          w_last_nxt  = w_pick_idx;
        end
      end
      S_GRANT: begin
        // Release uses the post-edge count so a final read accepted in the
        // same cycle still forces a drain.
        if (!w_own_req) begin
          if (w_out_cnt_nxt == '0) begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (w_out_cnt_nxt == '0) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // Output logic. While rst_n is low everything sits at its idle value.
  always_comb begin
    io_bus.req_rdy     = '0;
    io_bus.mem_vld     = 1'b0;
    io_bus.mem_we      = 1'b0;
    io_bus.mem_addr    = '0;
    io_bus.mem_wdata   = '0;
    io_bus.rsp_vld     = '0;
    io_bus.mem_rsp_rdy = 1'b1;
    io_bus.orphan      = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_IDLE: begin
          io_bus.orphan = io_bus.mem_rsp_vld;
        end
        S_GRANT: begin
          io_bus.mem_vld             = w_own_vld && !w_blocked;
          io_bus.mem_we              = w_own_we;
          io_bus.mem_addr            = io_bus.req_addr[r_last*AW +: AW];
          io_bus.mem_wdata           = io_bus.req_wdata[r_last*DW +: DW];
          io_bus.req_rdy[r_last]     = io_bus.mem_rdy && !w_blocked;
          io_bus.rsp_vld[r_last]     = io_bus.mem_rsp_vld;
          io_bus.mem_rsp_rdy         = io_bus.rsp_rdy[r_last];
        end
        S_DRAIN: begin
          io_bus.rsp_vld[r_last]     = io_bus.mem_rsp_vld;
          io_bus.mem_rsp_rdy         = io_bus.rsp_rdy[r_last];
        end
        default: begin
          io_bus.mem_rsp_rdy = 1'b1;
        end
      endcase
    end
  end

  assign io_bus.rsp_addr = io_bus.mem_rsp_addr;
  assign io_bus.rsp_data = io_bus.mem_rsp_data;
  assign io_bus.grant    = r_grant;
  assign o_dbg_state     = r_state;
  assign o_dbg_out_cnt   = r_out_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter. Requesters are driven from the main
// sequence; a small memory model accepts commands and returns read responses
// in order (data = {addr[15:0], ~addr[15:0]}); every accepted read pushes its
// expected {owner, addr, data} into exp_q and a monitor pops and compares on
// every response handshake. Inputs change just after the falling edge, checks
// happen 1-2 time units after the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  localparam int NREQ    = 3;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int MAX_OUT = 8;
  localparam int EW      = 2 + AW + DW;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();
  logic [1:0] dbg_state;
  logic [3:0] dbg_cnt;

  mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_OUT(MAX_OUT)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .io_bus        (bus),
    .o_dbg_state   (dbg_state),
    .o_dbg_out_cnt (dbg_cnt)
  );

  // ---------------- scoreboard state ----------------
  int             n_vec = 0;
  int             n_err = 0;
  logic [EW-1:0]  exp_q[$];
  logic [AW-1:0]  pend_q[$];
  bit             rsp_en   = 1'b0;
  bit             rdy_rand = 1'b0;
  bit             man_en   = 1'b0;
  bit             man_vld  = 1'b0;
  logic [AW-1:0]  man_addr = '0;
  bit             watch_g  = 1'b0;
  bit             g_bad    = 1'b0;
  int             orphan_cnt = 0;
  int             rsp_cnt[NREQ] = '{default: 0};

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // ---------------- memory model ----------------
  always @(posedge clk) begin
    if (bus.mem_vld === 1'b1 && bus.mem_rdy === 1'b1 && bus.mem_we === 1'b0)
      pend_q.push_back(bus.mem_addr);
    if (!man_en && bus.mem_rsp_vld === 1'b1 && bus.mem_rsp_rdy === 1'b1 && pend_q.size() > 0)
      void'(pend_q.pop_front());
  end

  always @(negedge clk) begin
    bus.mem_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (man_en) begin
      bus.mem_rsp_vld  = man_vld;
      bus.mem_rsp_addr = man_addr;
      bus.mem_rsp_data = mem_data(man_addr);
    end else if (rsp_en && pend_q.size() > 0) begin
      bus.mem_rsp_vld  = 1'b1;
      bus.mem_rsp_addr = pend_q[0];
      bus.mem_rsp_data = mem_data(pend_q[0]);
    end else begin
      bus.mem_rsp_vld  = 1'b0;
      bus.mem_rsp_addr = '0;
      bus.mem_rsp_data = '0;
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] got;
    logic [EW-1:0] e;
    #2;
    if (bus.orphan === 1'b1) orphan_cnt++;
    if (watch_g && bus.grant !== 3'b001) g_bad = 1'b1;
    for (int r = 0; r < NREQ; r++) begin
      if (bus.rsp_vld[r] === 1'b1 && bus.rsp_rdy[r] === 1'b1) begin
        got = {2'(r), bus.rsp_addr, bus.rsp_data};
        rsp_cnt[r]++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rsp_unexpected: got owner %0d addr 0x%0h, expected no response", r, bus.rsp_addr);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_err++;
            $display("FAIL rsp: got owner %0d addr 0x%0h data 0x%0h expected owner %0d addr 0x%0h data 0x%0h",
                     r, got[AW+DW-1:DW], got[DW-1:0], e[EW-1:AW+DW], e[AW+DW-1:DW], e[DW-1:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Called at a tick point; returns at the tick point after the handshake.
  task automatic do_cmd(input int r, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok;
    ok = 1'b0;
    bus.req_vld[r]              = 1'b1;
    bus.req_we[r]               = we;
    bus.req_addr[r*AW +: AW]    = a;
    bus.req_wdata[r*DW +: DW]   = d;
    #1;
    for (int c = 0; c < 200; c++) begin
      if (bus.req_rdy[r] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #2;
    end
    if (!ok) chk("cmd_timeout", 64'(bus.req_rdy[r]), 64'h1);
    else if (!we) exp_q.push_back({2'(r), a, mem_data(a)});
    tick();
    bus.req_vld[r] = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input string name);
    for (int i = 0; i < 500; i++) begin
      if (dbg_state == s) break;
      tick();
    end
    chk(name, 64'(dbg_state), 64'(s));
  endtask

  task automatic wait_exp_empty(input string name);
    for (int i = 0; i < 2000; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk(name, 64'(exp_q.size()), 64'h0);
  endtask

  // ---------------- main sequence ----------------
  logic [2:0] exp_rr[11] = '{3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b000,
                             3'b100, 3'b100, 3'b000, 3'b001, 3'b001};

  initial begin
    logic [2:0] g;
    logic [2:0] pend_raise;
    int         hold;
    int         oc0;

    bus.req       = '0;
    bus.req_vld   = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_rdy   = '1;

    // Reset values
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_state",   64'(dbg_state),        64'(ST_IDLE));
    chk("rst_grant",   64'(bus.grant),        64'h0);
    chk("rst_out_cnt", 64'(dbg_cnt),          64'h0);
    chk("rst_mem_vld", 64'(bus.mem_vld),      64'h0);
    chk("rst_req_rdy", 64'(bus.req_rdy),      64'h0);
    chk("rst_rsp_vld", 64'(bus.rsp_vld),      64'h0);
    chk("rst_rsp_rdy", 64'(bus.mem_rsp_rdy),  64'h1);
    chk("rst_orphan",  64'(bus.orphan),       64'h0);

    // Single owner: 144 reads 0x100..0x33C with random memory stalls
    rdy_rand = 1'b1;
    rsp_en   = 1'b1;
    bus.req[0] = 1'b1;
    tick();
    chk("t1_grant", 64'(bus.grant), 64'h1);
    watch_g = 1'b1;
    for (int i = 0; i < 144; i++) do_cmd(0, 1'b0, 32'h100 + 32'(4 * i), '0);
    wait_exp_empty("t1_rsp_done");
    watch_g  = 1'b0;
    rdy_rand = 1'b0;
    bus.req[0] = 1'b0;
    tick();
    chk("t1_state_idle", 64'(dbg_state),  64'(ST_IDLE));
    chk("t1_grant_idle", 64'(bus.grant),  64'h0);
    chk("t1_out_cnt",    64'(dbg_cnt),    64'h0);
    chk("t1_rsp_count",  64'(rsp_cnt[0]), 64'd144);
    chk("t1_grant_held", 64'(g_bad),      64'h0);

    // Round-robin from reset: each owner holds 2 cycles, then drops and re-raises
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req    = 3'b111;
    pend_raise = '0;
    hold       = 0;
    for (int k = 0; k < 11; k++) begin
      tick();
      g = bus.grant;
      chk("rr_grant", 64'(g), 64'(exp_rr[k]));
      if (g != 3'b000) begin
        hold++;
        if (hold == 2) begin
          bus.req    = bus.req & ~g;
          pend_raise = g;
          hold       = 0;
        end
      end else begin
        bus.req    = bus.req | pend_raise;
        pend_raise = '0;
      end
    end
    bus.req = '0;
    wait_state(ST_IDLE, "rr_idle");

    // Drain: owner 1 issues 5 reads with responses withheld, req[2] pending
    rsp_en = 1'b0;
    bus.req[1] = 1'b1;
    tick();
    chk("t3_grant", 64'(bus.grant), 64'h2);
    for (int i = 0; i < 5; i++) do_cmd(1, 1'b0, 32'h2000 + 32'(4 * i), '0);
    bus.req[1]     = 1'b0;
    bus.req[2]     = 1'b1;
    bus.req_vld[2] = 1'b1;
    bus.req_we[2]  = 1'b0;
    tick();
    chk("t3_state_drain", 64'(dbg_state),   64'(ST_DRAIN));
    chk("t3_mem_vld",     64'(bus.mem_vld), 64'h0);
    chk("t3_req_rdy",     64'(bus.req_rdy), 64'h0);
    chk("t3_out_cnt",     64'(dbg_cnt),     64'd5);
    chk("t3_grant_held",  64'(bus.grant),   64'h2);
    bus.req_vld[2] = 1'b0;
    rsp_en = 1'b1;
    wait_state(ST_IDLE, "t3_idle");
    chk("t3_grant_idle", 64'(bus.grant), 64'h0);
    tick();
    chk("t3_grant_next", 64'(bus.grant),  64'h4);
    chk("t3_rsp_count",  64'(rsp_cnt[1]), 64'd5);
    bus.req[2] = 1'b0;
    tick();
    wait_state(ST_IDLE, "t3_idle2");

    // Outstanding limit: 8 reads fill the window, 9th stalls, write passes
    rsp_en = 1'b0;
    bus.req[0] = 1'b1;
    tick();
    chk("t4_grant", 64'(bus.grant), 64'h1);
    for (int i = 0; i < 8; i++) do_cmd(0, 1'b0, 32'h4000 + 32'(4 * i), '0);
    chk("t4_out_cnt8", 64'(dbg_cnt), 64'd8);
    bus.req_vld[0]          = 1'b1;
    bus.req_we[0]           = 1'b0;
    bus.req_addr[0 +: AW]   = 32'h4020;
    tick();
    tick();
    chk("t4_rd_rdy_blocked", 64'(bus.req_rdy[0]), 64'h0);
    chk("t4_rd_vld_blocked", 64'(bus.mem_vld),    64'h0);
    bus.req_we[0]         = 1'b1;
    bus.req_addr[0 +: AW] = 32'h5000;
    bus.req_wdata[0 +: DW] = 32'hDEAD_BEEF;
    #1;
    chk("t4_wr_rdy", 64'(bus.req_rdy[0]), 64'h1);
    chk("t4_wr_vld", 64'(bus.mem_vld),    64'h1);
    tick();
    bus.req_vld[0] = 1'b0;
    chk("t4_out_cnt_wr", 64'(dbg_cnt), 64'd8);
    rsp_en = 1'b1;
    do_cmd(0, 1'b0, 32'h4020, '0);
    wait_exp_empty("t4_rsp_done");
    bus.req[0] = 1'b0;
    tick();
    wait_state(ST_IDLE, "t4_idle");
    chk("t4_out_cnt0", 64'(dbg_cnt), 64'h0);

    // Orphan in IDLE
    man_addr = 32'h000B_EEF0;
    man_vld  = 1'b1;
    man_en   = 1'b1;
    tick();
    chk("t5_orphan",      64'(bus.orphan),      64'h1);
    chk("t5_orphan_rdy",  64'(bus.mem_rsp_rdy), 64'h1);
    chk("t5_orphan_rvld", 64'(bus.rsp_vld),     64'h0);
    man_vld = 1'b0;
    tick();
    chk("t5_orphan_off", 64'(bus.orphan), 64'h0);
    man_en = 1'b0;

    // Reset during GRANT with two reads in flight
    rsp_en = 1'b0;
    bus.req[0] = 1'b1;
    tick();
    chk("t5_grant", 64'(bus.grant), 64'h1);
    do_cmd(0, 1'b0, 32'h6000, '0);
    do_cmd(0, 1'b0, 32'h6004, '0);
    chk("t5_out_cnt2", 64'(dbg_cnt), 64'd2);
    rst_n      = 1'b0;
    bus.req[0] = 1'b0;
    tick();
    chk("t5_rst_grant", 64'(bus.grant), 64'h0);
    chk("t5_rst_cnt",   64'(dbg_cnt),   64'h0);
    chk("t5_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst_n = 1'b1;
    exp_q.delete();
    oc0    = orphan_cnt;
    rsp_en = 1'b1;
    repeat (4) tick();
    chk("t5_orphans_after_rst", 64'(orphan_cnt - oc0), 64'd2);
    bus.req = 3'b011;
    tick();
    chk("t5_rr_after_rst", 64'(bus.grant), 64'h1);
    bus.req = '0;
    tick();
    wait_state(ST_IDLE, "t5_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
